uart_rx: RTL

Hardware UART receiver for the f8 test system on the iCEBreaker board. It is the receive counterpart to the serial TX pin currently driven through GPIO bit-banging. It oversamples the board RX line, frames 8N1 characters and buffers them in a small FIFO. Bytes are offered to the system bus through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state type, byte width
// and helpers that derive counter/pointer widths from the block parameters.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int BIT_IDX_W        = 3;
    localparam int DEF_CLKS_PER_BIT = 208;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Explicit encodings keep the state values stable for waveform decoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Width of the bit timer that counts down from CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    // Width of the FIFO read/write pointers.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two FIFO. Pointers wrap modulo DEPTH; a separate count one
// bit wider tells full from empty. A push while full is ignored unless a pop
// happens in the same cycle, in which case both take effect. rdata reads 0
// while empty so the head never exposes stale storage.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == COUNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling bit timer,
// framing FSM, sticky error flags and a byte FIFO toward the system bus.
//
// Handshake: a byte transfers on every rising clk edge where valid && ready.
// valid/data come straight from registered FIFO state, so neither depends
// combinationally on ready; data is only meaningful while valid is high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              power_on_reset_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              framing_error,
    output logic              overrun,
    input  logic              clear_errors,
    output uart_rx_state_t    o_dbg_state
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    // First wait lands on the middle of the start bit, later waits are one bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic                 r_sync1;
    logic                 r_rxs;
    uart_rx_state_t       r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [DATA_W-1:0]    r_shift;
    logic                 r_framing_error;
    logic                 r_overrun;

    logic              w_expire;
    logic              w_stop_sample;
    logic              w_push;
    logic              w_pop;
    logic              w_fe_set;
    logic              w_ovr_set;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [DATA_W-1:0] w_fifo_rdata;

    assign w_expire      = (r_cnt == '0);
    assign w_stop_sample = (r_state == STOP) && w_expire;
    assign w_push        = w_stop_sample && r_rxs;
    assign w_fe_set      = w_stop_sample && !r_rxs;
    assign w_pop         = valid && ready;
    // A full FIFO only drops the byte when nothing leaves in the same cycle.
    assign w_ovr_set     = w_push && w_fifo_full && !w_pop;

    assign valid         = !w_fifo_empty;
    assign data          = w_fifo_rdata;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;
    assign o_dbg_state   = r_state;

    // Bring the asynchronous pin into the clk domain; idle level is 1.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    // Framing FSM with bit timer: sample start, 8 data bits LSB first, stop.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_rxs) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_expire) begin
                        if (!r_rxs) begin
                            r_cnt     <= FULL_LOAD;
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_expire) begin
                        r_shift[r_bit_idx] <= r_rxs;
                        r_cnt              <= FULL_LOAD;
                        if (r_bit_idx == BIT_IDX_W'(DATA_W - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_expire) begin
                        // Re-arm half a bit early so back-to-back frames work.
                        r_state <= r_rxs ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must rise before another start counts.
                    if (r_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_fe_set) begin
                r_framing_error <= 1'b1;
            end else if (clear_errors) begin
                r_framing_error <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (power_on_reset_n),
        .push  (w_push),
        .wdata (r_shift),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

endmodule
